vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter_if.sv | 32 +++
 rtl/vram_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - signal bundle between the VRAM arbiter, fetch/snoop logic and VRAM pins
interface vram_arbiter_if;
  logic [2:0]  seq;
  logic        vidReq;
  logic [14:0] vidAddr;
  logic [7:0]  vidData;
  logic        vidDataValid;
  logic        wrValid;
  logic [14:0] wrAddr;
  logic [7:0]  wrData;
  logic        wrReady;
  logic        fifoEmpty;
  logic        overflow;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataIn;
  logic [7:0]  vramDataOut;
  logic        vramDrive;
  logic        nvramOE;
  logic        nvramWE;

  modport master (
    input  seq, vidReq, vidAddr, wrValid, wrAddr, wrData, vramDataIn,
    output vidData, vidDataValid, wrReady, fifoEmpty, overflow,
           vramAddr, vramDataOut, vramDrive, nvramOE, nvramWE
  );

  modport slave (
    output seq, vidReq, vidAddr, wrValid, wrAddr, wrData, vramDataIn,
    input  vidData, vidDataValid, wrReady, fifoEmpty, overflow,
           vramAddr, vramDataOut, vramDrive, nvramOE, nvramWE
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM port sequencer: one reserved video read per 8-cycle character,
// queued CPU writes drained in the remaining slots.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int VID_SLOT   = 0
) (
  input  logic           pixClk,
  input  logic           reset,
  vram_arbiter_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [2:0]    VID_OFF  = 3'(VID_SLOT);

  typedef enum logic [2:0] {IDLE, RD1, RD2, WSET, WPUL, WHLD} state_t;
  state_t state, nextState;

  logic [2:0] off;
  assign off = bus.seq - VID_OFF;

  logic [14:0]   qAddr [FIFO_DEPTH];
  logic [7:0]    qData [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count, countNext;
  logic          push, pop;

  assign push      = bus.wrValid && bus.wrReady;
  assign pop       = (state == WPUL);
  assign countNext = count + CW'(push) - CW'(pop);

  // A write may only start at off<=5 so its three cycles end by off 7.
  logic vidStart, wrStart;
  assign vidStart = (off == 3'd0) && bus.vidReq;
  assign wrStart  = (count != '0) && (off <= 3'd5) && !vidStart;

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // RD2 and WHLD dispatch directly so back-to-back slots lose no cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE, RD2, WHLD: begin
        if (vidStart)     nextState = RD1;
        else if (wrStart) nextState = WSET;
        else              nextState = IDLE;
      end
      RD1:     nextState = RD2;
      WSET:    nextState = WPUL;
      WPUL:    nextState = WHLD;
      default: nextState = IDLE;
    endcase
  end

  logic oeNext, weNext, driveNext, loadVid, loadWr;
  always_comb begin
    oeNext    = 1'b1;
    weNext    = 1'b1;
    driveNext = 1'b0;
    loadVid   = 1'b0;
    loadWr    = 1'b0;
    case (nextState)
      RD1: begin
        oeNext  = 1'b0;
        loadVid = 1'b1;
      end
      RD2:  oeNext = 1'b0;
      WSET: begin
        driveNext = 1'b1;
        loadWr    = 1'b1;
      end
      WPUL: begin
        driveNext = 1'b1;
        weNext    = 1'b0;
      end
      WHLD:    driveNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      bus.nvramOE      <= 1'b1;
      bus.nvramWE      <= 1'b1;
      bus.vramDrive    <= 1'b0;
      bus.vramAddr     <= '0;
      bus.vramDataOut  <= '0;
      bus.vidData      <= '0;
      bus.vidDataValid <= 1'b0;
    end else begin
      bus.nvramOE      <= oeNext;
      bus.nvramWE      <= weNext;
      bus.vramDrive    <= driveNext;
      bus.vidDataValid <= (state == RD2);
      if (state == RD2) bus.vidData <= bus.vramDataIn;
      if (loadVid) begin
        bus.vramAddr <= bus.vidAddr;
      end else if (loadWr) begin
        bus.vramAddr    <= qAddr[rdPtr];
        bus.vramDataOut <= qData[rdPtr];
      end
    end
  end

  // Queue storage needs no reset; the pointers and count define validity.
  always_ff @(posedge pixClk) begin
    if (push) begin
      qAddr[wrPtr] <= bus.wrAddr;
      qData[wrPtr] <= bus.wrData;
    end
  end

  always_ff @(posedge pixClk or posedge reset) begin
    if (reset) begin
      rdPtr         <= '0;
      wrPtr         <= '0;
      count         <= '0;
      bus.wrReady   <= 1'b1;
      bus.fifoEmpty <= 1'b1;
      bus.overflow  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count         <= countNext;
      bus.wrReady   <= (countNext != FULL_CNT);
      bus.fifoEmpty <= (countNext == '0);
      if (bus.wrValid && !bus.wrReady) bus.overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed and randomized checks of vram_arbiter against a
// slot-occupancy timeline model.
module tb_vram_arbiter;
  localparam int DEPTH    = 4;
  localparam int VID_SLOT = 0;

  logic pixClk = 1'b0;
  logic reset  = 1'b0;

  vram_arbiter_if bus();

  vram_arbiter #(.FIFO_DEPTH(DEPTH), .VID_SLOT(VID_SLOT)) dut (
    .pixClk(pixClk),
    .reset (reset),
    .bus   (bus)
  );

  always #20 pixClk = ~pixClk;

  int nVec = 0;
  int nErr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each edge either books the port for a read (2 OE-low cycles, data
  // captured 2 edges later) or a write (3 drive cycles, WE low in the middle one).
  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         q[$];
  int          edgeNo, busyUntil, capEdge, popEdge;
  logic [14:0] mAddr;
  logic [7:0]  mDout, mVidData;
  logic        mOvf;
  logic        ringOE [4];
  logic        ringWE [4];
  logic        ringDrv [4];
  logic        eOE, eWE, eDrv, eValid;
  logic [2:0]  hc;

  task automatic model_reset();
    q.delete();
    edgeNo = 0; busyUntil = 0; capEdge = -1; popEdge = -1;
    mAddr = '0; mDout = '0; mVidData = '0; mOvf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ringOE[i] = 1'b1; ringWE[i] = 1'b1; ringDrv[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int   off;
    logic full;
    off  = (int'(bus.seq) - VID_SLOT) & 7;
    full = (q.size() == DEPTH);
    if (edgeNo >= busyUntil) begin
      if (off == 0 && bus.vidReq) begin
        mAddr = bus.vidAddr;
        for (int k = 0; k < 2; k++) ringOE[(edgeNo + k) % 4] = 1'b0;
        capEdge   = edgeNo + 2;
        busyUntil = edgeNo + 2;
      end else if (q.size() > 0 && off <= 5) begin
        mAddr = q[0].a;
        mDout = q[0].d;
        for (int k = 0; k < 3; k++) ringDrv[(edgeNo + k) % 4] = 1'b1;
        ringWE[(edgeNo + 1) % 4] = 1'b0;
        popEdge   = edgeNo + 2;
        busyUntil = edgeNo + 3;
      end
    end
    eValid = (edgeNo == capEdge);
    if (eValid) mVidData = bus.vramDataIn;
    if (edgeNo == popEdge) void'(q.pop_front());
    if (bus.wrValid) begin
      if (full) mOvf = 1'b1;
      else      q.push_back(wr_t'{bus.wrAddr, bus.wrData});
    end
    eOE  = ringOE[edgeNo % 4];
    eWE  = ringWE[edgeNo % 4];
    eDrv = ringDrv[edgeNo % 4];
    ringOE[edgeNo % 4]  = 1'b1;
    ringWE[edgeNo % 4]  = 1'b1;
    ringDrv[edgeNo % 4] = 1'b0;
    edgeNo++;
  endtask

  task automatic compare();
    check("nvramOE",      bus.nvramOE,      eOE);
    check("nvramWE",      bus.nvramWE,      eWE);
    check("vramDrive",    bus.vramDrive,    eDrv);
    check("vramAddr",     bus.vramAddr,     mAddr);
    check("vramDataOut",  bus.vramDataOut,  mDout);
    check("vidData",      bus.vidData,      mVidData);
    check("vidDataValid", bus.vidDataValid, eValid);
    check("wrReady",      bus.wrReady,      q.size() != DEPTH);
    check("fifoEmpty",    bus.fifoEmpty,    q.size() == 0);
    check("overflow",     bus.overflow,     mOvf);
    check("oe_we_excl",   bus.nvramOE | bus.nvramWE, 1'b1);
    check("drive_vs_oe",  !(bus.vramDrive && !bus.nvramOE), 1'b1);
  endtask

  task automatic tick();
    bus.seq = hc;
    @(posedge pixClk);
    model_edge();
    @(negedge pixClk);
    compare();
    hc = hc + 3'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setWr(input logic v, input logic [14:0] a, input logic [7:0] d);
    bus.wrValid = v;
    bus.wrAddr  = a;
    bus.wrData  = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_oe"},    bus.nvramOE,      1'b1);
    check({tag, "_we"},    bus.nvramWE,      1'b1);
    check({tag, "_drv"},   bus.vramDrive,    1'b0);
    check({tag, "_addr"},  bus.vramAddr,     15'h0);
    check({tag, "_dout"},  bus.vramDataOut,  8'h0);
    check({tag, "_vdat"},  bus.vidData,      8'h0);
    check({tag, "_vval"},  bus.vidDataValid, 1'b0);
    check({tag, "_ovf"},   bus.overflow,     1'b0);
    check({tag, "_rdy"},   bus.wrReady,      1'b1);
    check({tag, "_empty"}, bus.fifoEmpty,    1'b1);
  endtask

  initial begin
    int wrRate;
    bus.seq = 3'd0; bus.vidReq = 1'b0; bus.vidAddr = '0; bus.vramDataIn = '0;
    setWr(1'b0, '0, '0);
    hc = 3'd0;
    model_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge pixClk);
    check_reset_state("rst0");
    reset = 1'b0;
    model_reset();

    // Character 1: plain video read.
    bus.vidReq = 1'b1; bus.vidAddr = 15'h1234; bus.vramDataIn = 8'hA5;
    tick(); check("s1_oe_off0", bus.nvramOE, 1'b0); check("s1_addr", bus.vramAddr, 15'h1234);
    tick(); check("s1_oe_off1", bus.nvramOE, 1'b0);
    tick(); check("s1_oe_off2", bus.nvramOE, 1'b1);
    check("s1_valid_off2", bus.vidDataValid, 1'b1); check("s1_data", bus.vidData, 8'hA5);
    tick(); check("s1_valid_off3", bus.vidDataValid, 1'b0);
    ticks(4);

    // Character 2: single push at off 1, then four pushes from off 6.
    bus.vidAddr = 15'h0200; bus.vramDataIn = 8'h5A;
    tick();
    setWr(1'b1, 15'h0100, 8'h3C); tick(); setWr(1'b0, '0, '0);
    tick(); check("s2_drv_off2", bus.vramDrive, 1'b1); check("s2_we_off2", bus.nvramWE, 1'b1);
    check("s2_addr", bus.vramAddr, 15'h0100); check("s2_dout", bus.vramDataOut, 8'h3C);
    tick(); check("s2_we_off3", bus.nvramWE, 1'b0);
    tick(); check("s2_we_off4", bus.nvramWE, 1'b1); check("s2_drv_off4", bus.vramDrive, 1'b1);
    check("s2_empty_off4", bus.fifoEmpty, 1'b1);
    tick(); check("s2_drv_off5", bus.vramDrive, 1'b0);
    setWr(1'b1, 15'h0A01, 8'h11); tick();
    setWr(1'b1, 15'h0A02, 8'h22); tick();
    // Character 3
    setWr(1'b1, 15'h0A03, 8'h33); tick();
    setWr(1'b1, 15'h0A04, 8'h44); tick(); check("s3_full_rdy", bus.wrReady, 1'b0);
    setWr(1'b1, 15'h0A05, 8'h55); tick(); check("s3_overflow", bus.overflow, 1'b1);
    setWr(1'b0, '0, '0);
    ticks(13);

    // Character 5: write queued at off 5 must wait for off 2 of the next character.
    ticks(5);
    setWr(1'b1, 15'h0B06, 8'h66); tick(); setWr(1'b0, '0, '0);
    tick(); check("s4_drv_off6", bus.vramDrive, 1'b0);
    tick(); check("s4_drv_off7", bus.vramDrive, 1'b0);
    tick(); check("s4_oe_off0", bus.nvramOE, 1'b0);
    tick();
    tick(); check("s4_drv_off2", bus.vramDrive, 1'b1); check("s4_addr", bus.vramAddr, 15'h0B06);
    ticks(3);
    setWr(1'b1, 15'h0C07, 8'h77); tick();
    setWr(1'b1, 15'h0C08, 8'h88); tick(); setWr(1'b0, '0, '0);

    // Character 7: no video, two queued writes start at off 0 and 3.
    bus.vidReq = 1'b0;
    tick(); check("s5_drv_off0", bus.vramDrive, 1'b1); check("s5_addr0", bus.vramAddr, 15'h0C07);
    tick(); check("s5_we_off1", bus.nvramWE, 1'b0);
    tick(); check("s5_valid_off2", bus.vidDataValid, 1'b0);
    tick(); check("s5_drv_off3", bus.vramDrive, 1'b1); check("s5_addr3", bus.vramAddr, 15'h0C08);
    tick(); check("s5_we_off4", bus.nvramWE, 1'b0);
    ticks(3);

    // Character 8: reset lands while the write pulse is low.
    bus.vidReq = 1'b1;
    tick();
    setWr(1'b1, 15'h0D09, 8'h99); tick();
    setWr(1'b1, 15'h0D0A, 8'hAA); tick(); setWr(1'b0, '0, '0);
    tick(); check("s6_we_wpul", bus.nvramWE, 1'b0);
    #5 reset = 1'b1;
    #1 check_reset_state("rst_wpul");
    repeat (2) @(negedge pixClk);
    reset = 1'b0;
    model_reset();
    hc = 3'd0;

    // Random traffic.
    wrRate = 2;
    for (int i = 0; i < 1600; i++) begin
      if (i % 32 == 0) wrRate = $urandom_range(0, 7);
      bus.vidReq     = ($urandom_range(0, 3) != 0);
      bus.vidAddr    = 15'($urandom);
      bus.vramDataIn = 8'($urandom);
      setWr($urandom_range(0, 7) < wrRate, 15'($urandom), 8'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
